// File: rtl/mem_store.sv
// Store unit: formats SB/SH/SW into DMEM/IMEM byte-lane writes, feeds the UART TX FIFO, pulses counter clear.
// Memory writes are combinational; a TX store to a full FIFO holds stall_o until a slot frees.

module mem_store_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop_rdy,
  output logic                       pop_vld,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (count == FULL_CNT);
  assign pop_vld = (count != '0);
  assign pop_dat = mem[rd_ptr];
  assign push    = push_vld && !full;
  assign pop     = pop_vld && pop_rdy;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module mem_store #(
  parameter int TXBUF_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   control_store_i,
  input  logic [31:0]                  addr_i,
  input  logic [31:0]                  data_i,
  input  logic [31:0]                  pc_i,
  output logic [3:0]                   dmem_wea_o,
  output logic [13:0]                  dmem_addr_o,
  output logic [31:0]                  dmem_dina_o,
  output logic [3:0]                   imem_wea_o,
  output logic [13:0]                  imem_addr_o,
  output logic [31:0]                  imem_dina_o,
  output logic [7:0]                   uart_tx_data_o,
  output logic                         uart_tx_valid_o,
  input  logic                         uart_tx_ready_i,
  output logic                         counter_rst_o,
  output logic                         stall_o,
  output logic [$clog2(TXBUF_DEPTH):0] txbuf_count_o,
  output logic                         misalign_o
);
  typedef enum logic [1:0] {ST_NONE = 2'b00, ST_SB = 2'b01, ST_SH = 2'b10, ST_SW = 2'b11} store_t;

  localparam logic [31:0] TX_ADDR  = 32'h8000_0008;
  localparam logic [31:0] CTR_ADDR = 32'h8000_0018;

  logic [3:0]  region;
  logic        dmem_sel;
  logic        imem_sel;
  logic        store_en;
  logic [3:0]  lane;
  logic [31:0] wdat;
  logic        tx_hit;
  logic        tx_full;
  logic        ctr_hit;
  logic        unused_pc;

  assign unused_pc = ^{pc_i[31], pc_i[29:0]};

  assign region   = addr_i[31:28];
  assign dmem_sel = (region == 4'h1) || (region == 4'h3);
  // IMEM is only writable while running out of the BIOS.
  assign imem_sel = ((region == 4'h2) || (region == 4'h3)) && pc_i[30];

  always_comb begin
    lane       = '0;
    wdat       = '0;
    misalign_o = 1'b0;
    case (control_store_i)
      ST_SB: begin
        lane = 4'b0001 << addr_i[1:0];
        wdat = {4{data_i[7:0]}};
      end
      ST_SH: begin
        lane       = addr_i[1] ? 4'b1100 : 4'b0011;
        wdat       = {2{data_i[15:0]}};
        misalign_o = addr_i[0];
      end
      ST_SW: begin
        lane       = 4'b1111;
        wdat       = data_i;
        misalign_o = (addr_i[1:0] != 2'b00);
      end
      default: begin
        lane = '0;
        wdat = '0;
      end
    endcase
  end

  assign store_en    = !rst && (control_store_i != ST_NONE) && !misalign_o;
  assign dmem_wea_o  = (store_en && dmem_sel) ? lane : 4'b0000;
  assign imem_wea_o  = (store_en && imem_sel) ? lane : 4'b0000;
  assign dmem_addr_o = addr_i[15:2];
  assign imem_addr_o = addr_i[15:2];
  assign dmem_dina_o = wdat;
  assign imem_dina_o = wdat;

  assign tx_hit  = ((control_store_i == ST_SB) || (control_store_i == ST_SW))
                   && (addr_i == TX_ADDR) && !misalign_o;
  assign stall_o = tx_hit && tx_full;
  assign ctr_hit = (control_store_i != ST_NONE) && (addr_i == CTR_ADDR) && !misalign_o;

  mem_store_fifo #(
    .WIDTH (8),
    .DEPTH (TXBUF_DEPTH)
  ) u_txbuf (
    .clk      (clk),
    .rst      (rst),
    .push_vld (tx_hit),
    .push_dat (data_i[7:0]),
    .pop_rdy  (uart_tx_ready_i),
    .pop_vld  (uart_tx_valid_o),
    .pop_dat  (uart_tx_data_o),
    .full     (tx_full),
    .count    (txbuf_count_o)
  );

  always_ff @(posedge clk) begin
    if (rst) counter_rst_o <= 1'b0;
    else     counter_rst_o <= ctr_hit;
  end
endmodule

// File: tb/tb_mem_store.sv
// Scoreboard bench for mem_store: stimulus queues expected writes, TX bytes and counter pulses; monitors compare.
module tb_mem_store;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] TX  = 32'h8000_0008;
  localparam logic [31:0] CTR = 32'h8000_0018;
  localparam logic [1:0] NONE = 2'b00, SB = 2'b01, SH = 2'b10, SW = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    ctl;
  logic [31:0]   addr, data, pc;
  logic [3:0]    dmem_wea, imem_wea;
  logic [13:0]   dmem_addr, imem_addr;
  logic [31:0]   dmem_dina, imem_dina;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_ready;
  logic          counter_rst, stall, misalign;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  mem_store #(.TXBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .control_store_i(ctl), .addr_i(addr), .data_i(data), .pc_i(pc),
    .dmem_wea_o(dmem_wea), .dmem_addr_o(dmem_addr), .dmem_dina_o(dmem_dina),
    .imem_wea_o(imem_wea), .imem_addr_o(imem_addr), .imem_dina_o(imem_dina),
    .uart_tx_data_o(tx_data), .uart_tx_valid_o(tx_valid), .uart_tx_ready_i(tx_ready),
    .counter_rst_o(counter_rst), .stall_o(stall), .txbuf_count_o(count), .misalign_o(misalign)
  );

  typedef struct {
    logic [3:0]  dwea;
    logic [3:0]  iwea;
    logic [13:0] waddr;
    logic [31:0] dina;
    logic        mis;
  } mem_exp_t;

  mem_exp_t   mem_q[$];
  logic [7:0] tx_q[$];
  int         ctr_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  bit         mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (no expectation queued or bound expired)", name);
  endtask

  // Monitors: memory writes/misalign, UART handshakes, counter pulses
  always @(negedge clk) begin
    if (mon_en && (dmem_wea != 4'd0 || imem_wea != 4'd0 || misalign)) begin
      if (mem_q.size() == 0) fail_now("mem_unexpected");
      else begin
        mem_exp_t e;
        e = mem_q.pop_front();
        check("dmem_wea", 32'(dmem_wea), 32'(e.dwea));
        check("imem_wea", 32'(imem_wea), 32'(e.iwea));
        check("dmem_addr", 32'(dmem_addr), 32'(e.waddr));
        check("imem_addr", 32'(imem_addr), 32'(e.waddr));
        check("dmem_dina", dmem_dina, e.dina);
        check("imem_dina", imem_dina, e.dina);
        check("misalign", 32'(misalign), 32'(e.mis));
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) fail_now("tx_unexpected");
      else check("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (mon_en && counter_rst) begin
      if (ctr_q.size() == 0) fail_now("ctr_unexpected");
      else check("ctr_cycle", 32'(cyc), 32'(ctr_q.pop_front()));
    end
  end

  task automatic exp_mem(input logic [3:0] dwea, input logic [3:0] iwea, input logic [13:0] waddr,
                         input logic [31:0] dina, input logic mis);
    mem_exp_t e;
    e.dwea = dwea; e.iwea = iwea; e.waddr = waddr; e.dina = dina; e.mis = mis;
    mem_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the store retires.
  task automatic do_store(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] p);
    int n;
    n = 0;
    ctl = c; addr = a; data = d; pc = p;
    @(negedge clk);
    while (stall && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (stall) fail_now("store_stall_timeout");
    if (c != NONE && a == CTR) ctr_q.push_back(cyc + 1);
    @(posedge clk); #1;
    ctl = NONE; addr = 32'd0; data = 32'd0; pc = 32'd0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (count != '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(count), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ctl = NONE; addr = 32'd0; data = 32'd0; pc = 32'd0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ctl = SW; addr = 32'h3000_0000; data = 32'hDEAD_BEEF; pc = 32'h4000_0000;
    @(negedge clk);
    check("rst_dmem_wea", 32'(dmem_wea), 32'd0);
    check("rst_imem_wea", 32'(imem_wea), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; ctl = NONE; addr = 32'd0; data = 32'd0; pc = 32'd0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_count", 32'(count), 32'd0);
    check("reset_valid", 32'(tx_valid), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_ctr", 32'(counter_rst), 32'd0);
    @(posedge clk); #1;

    // Memory-path vectors
    exp_mem(4'b1000, 4'b0000, 14'h0, 32'hABAB_ABAB, 1'b0);
    do_store(SB, 32'h1000_0003, 32'h0000_00AB, 32'h0);
    exp_mem(4'b1111, 4'b1111, 14'h4, 32'h1234_5678, 1'b0);
    do_store(SW, 32'h3000_0010, 32'h1234_5678, 32'h4000_0000);
    exp_mem(4'b1111, 4'b0000, 14'h4, 32'h1234_5678, 1'b0);
    do_store(SW, 32'h3000_0010, 32'h1234_5678, 32'h0000_1000);
    exp_mem(4'b0000, 4'b0000, 14'h0, 32'h5678_5678, 1'b1);
    do_store(SH, 32'h1000_0001, 32'h1234_5678, 32'h0);
    exp_mem(4'b0000, 4'b1100, 14'h1, 32'hBEEF_BEEF, 1'b0);
    do_store(SH, 32'h2000_0006, 32'hCAFE_BEEF, 32'h4000_0000);
    exp_mem(4'b0000, 4'b0000, 14'h0, 32'h0BAD_F00D, 1'b1);
    do_store(SW, 32'h3000_0002, 32'h0BAD_F00D, 32'h4000_0000);
    exp_mem(4'b0000, 4'b0010, 14'h0, 32'h5A5A_5A5A, 1'b0);
    do_store(SB, 32'h2000_0001, 32'h0000_005A, 32'h4000_0000);
    do_store(SB, 32'h2000_0001, 32'h0000_005A, 32'h0);
    do_store(NONE, 32'h1000_0000, 32'hFFFF_FFFF, 32'h4000_0000);
    do_store(SW, 32'h4000_0000, 32'hFFFF_FFFF, 32'h4000_0000);
    exp_mem(4'b0100, 4'b0000, 14'h0, 32'h7777_7777, 1'b0);
    do_store(SB, 32'h1000_0002, 32'h0000_0077, 32'h0);

    // Counter clear pulses
    do_store(SW, CTR, 32'h0000_0001, 32'h0);
    do_store(SB, CTR, 32'h0000_0001, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // UART path with ready high; other IO addresses and misaligned TX stores are ignored
    tx_ready = 1'b1;
    tx_q.push_back(8'h44);
    do_store(SW, TX, 32'h1122_3344, 32'h0);
    wait_empty("drain_single");
    do_store(SB, 32'h8000_000C, 32'h0000_0099, 32'h0);
    exp_mem(4'b0000, 4'b0000, 14'h2, 32'hDEAD_0001, 1'b1);
    do_store(SW, 32'h8000_000A, 32'hDEAD_0001, 32'h0);
    @(negedge clk);
    check("io_ignored_count", 32'(count), 32'd0);
    @(posedge clk); #1;

    // Fill to full, stall the fifth byte, release one slot
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_q.push_back(8'hA1 + 8'(i));
      do_store(SB, TX, 32'h0000_00A1 + 32'(i), 32'h0);
    end
    @(negedge clk);
    check("full_count", 32'(count), 32'd4);
    @(posedge clk); #1;
    tx_q.push_back(8'hA5);
    ctl = SB; addr = TX; data = 32'h0000_00A5;
    @(negedge clk);
    check("full_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk);
    check("stall_during_pop", 32'(stall), 32'd1);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    @(negedge clk);
    check("stall_released", 32'(stall), 32'd0);
    check("count_after_pop", 32'(count), 32'd3);
    @(posedge clk); #1;
    ctl = NONE; addr = 32'd0; data = 32'd0;
    @(negedge clk);
    check("fifth_accepted", 32'(count), 32'd4);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_empty("drain_full");

    // Reset mid-operation discards buffered bytes
    tx_ready = 1'b0;
    do_store(SB, TX, 32'h0000_0055, 32'h0);
    do_store(SB, TX, 32'h0000_0066, 32'h0);
    do_store(SB, TX, 32'h0000_0077, 32'h0);
    @(negedge clk);
    check("pre_reset_count", 32'(count), 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset_count", 32'(count), 32'd0);
    check("mid_reset_valid", 32'(tx_valid), 32'd0);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    @(negedge clk);
    check("mem_q_left", 32'(mem_q.size()), 32'd0);
    check("tx_q_left", 32'(tx_q.size()), 32'd0);
    check("ctr_q_left", 32'(ctr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
